// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared types and constants for the serial transmit path.
//               Holds the transmit FSM state encoding, the UART frame data
//               width and the default baud divider for a 50 MHz clock at
//               115200 baud.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Transmit FSM states; explicit 2-bit encoding so waveforms stay readable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_fifo.sv
`default_nettype none
// ============================================================================
// Module      : serial_fifo
// Description : Parameterised synchronous FIFO. Head data is presented
//               combinationally from the read pointer. Full/empty are derived
//               from a registered occupancy count. Pushes while full and pops
//               while empty are ignored.
// Ports       : clk_i   - clock, rising edge
//               rst_ni  - asynchronous active-low reset
//               push_i  - write request, data_i captured when not full
//               data_i  - write data
//               pop_i   - read request, advances head when not empty
//               head_o  - current head entry
//               full_o  - count == DEPTH
//               empty_o - count == 0
//               count_o - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Acceptance is judged on the pre-edge count only, so a push into a full
  // FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok = push_i & ~full_o;
  assign w_pop_ok  = pop_i  & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule : serial_fifo
`default_nettype wire

// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_fifo
// Description : Buffered UART 8N1 transmitter. Bytes written by the CPU serial
//               port are queued in a small FIFO and shifted out LSB first on
//               a registered tx line, so single-cycle stores are decoupled
//               from the bit rate.
// Ports       : clock        - system clock, rising edge
//               reset        - asynchronous active-low reset
//               data_in      - byte to transmit
//               wren_in      - one-cycle write strobe
//               ready_out    - 1 when the FIFO is not full
//               tx_out       - UART line, idles high
//               busy_out     - frame in progress or FIFO non-empty
//               level_out    - FIFO occupancy
//               overflow_out - sticky: a write was dropped while full
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          wren_in,
  output logic                          ready_out,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          overflow_out
);

  localparam int                BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  // Elaboration-time guards on the parameter set.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("serial_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("serial_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(CLKS_PER_BIT)) begin : g_bad_cnt_w
    $error("serial_tx_fifo: CNT_W too narrow for CLKS_PER_BIT");
  end

  tx_state_t                      state_q, state_d;
  logic [CNT_W-1:0]               baud_q,  baud_d;
  logic [BIT_W-1:0]               bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]      shreg_q, shreg_d;
  logic                           tx_q,    tx_d;
  logic                           ovf_q,   ovf_d;

  logic                           w_fifo_pop;
  logic [7:0]                     w_fifo_head;
  logic                           w_fifo_full;
  logic                           w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]    w_fifo_count;
  logic                           w_bit_done;

  serial_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (wren_in),
    .data_i  (data_in),
    .pop_i   (w_fifo_pop),
    .head_o  (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign w_bit_done = (baud_q == BAUD_LAST);

  // --------------------------------------------------------------------------
  // State register (plus datapath registers that advance with it)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!w_fifo_empty)                       state_d = START;
      START:   if (w_bit_done)                          state_d = DATA;
      DATA:    if (w_bit_done && bit_idx_q == BIT_LAST) state_d = STOP;
      STOP:    if (w_bit_done)                          state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_fifo_pop = 1'b0;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    ovf_d      = ovf_q | (wren_in & w_fifo_full);

    case (state_q)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          shreg_d    = w_fifo_head;
          baud_d     = '0;
        end
      end
      START: begin
        if (w_bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (w_bit_done) begin
          baud_d    = '0;
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + BIT_W'(1);
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (w_bit_done) begin
          baud_d = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        baud_d = '0;
      end
    endcase

    // The line level is a function of where the FSM will be after this edge,
    // registered so it changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_out       = tx_q;
  assign ready_out    = ~w_fifo_full;
  assign level_out    = w_fifo_count;
  assign overflow_out = ovf_q;
  assign busy_out     = (state_q != IDLE) | ~w_fifo_empty;

endmodule : serial_tx_fifo
`default_nettype wire
